// File: rtl/mam_req_arbiter.sv
// mam_req_arbiter: two-requester, whole-transaction arbiter for the MAM req/write/read channels.
// Optional feature macro MAM_ARB_FIXED_PRIO_EN: port 0 wins ties (no round-robin pointer).
module mam_req_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    s_req_valid,
  output logic [1:0]                    s_req_ready,
  input  logic [1:0]                    s_req_rw,
  input  logic [2*ADDR_WIDTH-1:0]       s_req_addr,
  input  logic [1:0]                    s_req_burst,
  input  logic [27:0]                   s_req_beats,
  input  logic [1:0]                    s_write_valid,
  input  logic [2*DATA_WIDTH-1:0]       s_write_data,
  input  logic [2*(DATA_WIDTH/8)-1:0]   s_write_strb,
  output logic [1:0]                    s_write_ready,
  output logic [1:0]                    s_read_valid,
  output logic [DATA_WIDTH-1:0]         s_read_data,
  input  logic [1:0]                    s_read_ready,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic                          m_req_rw,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  output logic                          m_req_burst,
  output logic [13:0]                   m_req_beats,
  output logic                          m_write_valid,
  output logic [DATA_WIDTH-1:0]         m_write_data,
  output logic [DATA_WIDTH/8-1:0]       m_write_strb,
  input  logic                          m_write_ready,
  input  logic                          m_read_valid,
  input  logic [DATA_WIDTH-1:0]         m_read_data,
  output logic                          m_read_ready,
  output logic [1:0]                    grant
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  grant_r;
  logic [13:0] beat_cnt_r;
  logic        sel_s;
  logic        win_s;
  logic        req_hs_s;
  logic        write_hs_s;
  logic        read_hs_s;
  logic        txn_end_s;
  logic [13:0] load_cnt_s;

  assign sel_s       = grant_r[1];
  assign grant       = grant_r;
  assign s_read_data = m_read_data;

`ifdef MAM_ARB_FIXED_PRIO_EN
  assign win_s = s_req_valid[1] & ~s_req_valid[0];
`else
  logic prio_r;

  // On a tie prio_r names the winner; it flips to the other port after each transaction
  assign win_s = (s_req_valid == 2'b11) ? prio_r : s_req_valid[1];

  // Round-robin pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (txn_end_s) begin
      prio_r <= ~sel_s;
    end
  end
`endif

  // Datapath mux: the owner's request/write fields, port 0 when no owner
  always_comb begin
    if (sel_s) begin
      m_req_rw     = s_req_rw[1];
      m_req_addr   = s_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      m_req_burst  = s_req_burst[1];
      m_req_beats  = s_req_beats[27:14];
      m_write_data = s_write_data[2*DATA_WIDTH-1:DATA_WIDTH];
      m_write_strb = s_write_strb[2*STRB_WIDTH-1:STRB_WIDTH];
    end else begin
      m_req_rw     = s_req_rw[0];
      m_req_addr   = s_req_addr[ADDR_WIDTH-1:0];
      m_req_burst  = s_req_burst[0];
      m_req_beats  = s_req_beats[13:0];
      m_write_data = s_write_data[DATA_WIDTH-1:0];
      m_write_strb = s_write_strb[STRB_WIDTH-1:0];
    end
  end

  // Handshake routing: only the owner sees ready/valid, and only in the matching phase
  always_comb begin
    m_req_valid   = 1'b0;
    s_req_ready   = 2'b00;
    m_write_valid = 1'b0;
    s_write_ready = 2'b00;
    s_read_valid  = 2'b00;
    m_read_ready  = 1'b0;
    case (state_r)
      ST_REQ: begin
        m_req_valid        = s_req_valid[sel_s];
        s_req_ready[sel_s] = m_req_ready;
      end
      ST_WRITE: begin
        m_write_valid        = s_write_valid[sel_s];
        s_write_ready[sel_s] = m_write_ready;
      end
      ST_READ: begin
        s_read_valid[sel_s] = m_read_valid;
        m_read_ready        = s_read_ready[sel_s];
      end
      default: m_req_valid = 1'b0;
    endcase
  end

  assign req_hs_s   = m_req_valid & m_req_ready;
  assign write_hs_s = m_write_valid & m_write_ready;
  assign read_hs_s  = m_read_valid & m_read_ready;
  assign txn_end_s  = (write_hs_s | read_hs_s) & (beat_cnt_r == 14'd1);
  // A burst with zero beats still moves one beat
  assign load_cnt_s = (m_req_burst && (m_req_beats != 14'd0)) ? m_req_beats : 14'd1;

  // Transaction FSM: arbitrate, forward the request, then count data beats down to the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= 2'b00;
      beat_cnt_r <= 14'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|s_req_valid) begin
            grant_r <= win_s ? 2'b10 : 2'b01;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_hs_s) begin
            beat_cnt_r <= load_cnt_s;
            state_r    <= m_req_rw ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE, ST_READ: begin
          if (write_hs_s | read_hs_s) begin
            beat_cnt_r <= beat_cnt_r - 14'd1;
          end
          if (txn_end_s) begin
            state_r <= ST_IDLE;
            grant_r <= 2'b00;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= 2'b00;
        end
      endcase
    end
  end

endmodule
